// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calculator scheduler slice.
//
// Contents:
//   DW_DEFAULT  default operand width (result width is 2*DW)
//   OP_*        two-bit operation encoding used on req*_op
//   state_t     controller FSM state encoding
//
// Optional feature macro used by calc_sched: CALC_DIVZERO_ERR_EN
package calc_pkg;

  localparam int DW_DEFAULT = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/calc_div_seq.sv
// calc_div_seq -- sequential restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load dividend/divisor and begin a DW-cycle divide
//   dividend   DW-bit numerator (sampled on start)
//   divisor    DW-bit denominator (sampled on start)
//   done       high during the final iteration cycle
//   quotient   quotient after the current iteration (final when done=1)
//   remainder  remainder after the current iteration (final when done=1)
//
// The outputs are the combinational result of the step being performed this
// cycle, so the caller can capture the final answer on the same edge that
// completes the last iteration. A zero divisor needs no special case: every
// trial subtract succeeds, giving an all-ones quotient and remainder = dividend.
module calc_div_seq
  import calc_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;

  logic [DW:0]   shifted;
  logic [DW-1:0] diff;
  logic          take;
  logic [DW-1:0] rem_next;
  logic [DW-1:0] quo_next;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB. When the trial subtract
  // succeeds the true difference is below the divisor, so DW bits suffice.
  always_comb begin
    shifted  = {rem_q, quo_q[DW-1]};
    diff     = shifted[DW-1:0] - dvs_q;
    take     = (shifted >= {1'b0, dvs_q});
    rem_next = take ? diff : shifted[DW-1:0];
    quo_next = {quo_q[DW-2:0], take};
  end

  assign done      = active_q && (cnt_q == CW'(DW - 1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_sched.sv
// calc_sched -- round-robin sequencer sharing one add/sub/mul/div unit
// between two requesters, returning one tagged result at a time.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (0 or 1)
//   reqN_op, reqN_a, reqN_b     operation (00 add, 01 sub, 10 mul, 11 div), operands
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester that issued the result
//   rsp_data                    2*DW-bit result (divide: {remainder, quotient})
//   rsp_err                     divide-by-zero flag (only with CALC_DIVZERO_ERR_EN)
//   busy                        high whenever the FSM is not IDLE
//
// Configuration macro: CALC_DIVZERO_ERR_EN -- when defined, a divide by zero
// bypasses the divider, returns zero data and raises rsp_err.
module calc_sched
  import calc_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*DW-1:0] rsp_data,
`ifdef CALC_DIVZERO_ERR_EN
  output logic            rsp_err,
`endif
  output logic            busy
);

  state_t state;
  state_t state_next;

  logic            ptr;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic            sel_id;
  logic [1:0]      sel_op;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_divzero;
  logic            div_start;

  logic [1:0]      op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            id_q;
  logic [2*DW-1:0] exec_result;

  logic            div_done;
  logic [DW-1:0]   div_quo;
  logic [DW-1:0]   div_rem;

  // ptr holds the last granted requester; on a tie the other one wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE) begin
      grant0 = req0_valid && (!req1_valid || ptr);
      grant1 = req1_valid && (!req0_valid || !ptr);
    end
  end

  assign accept     = grant0 | grant1;
  assign sel_id     = grant1;
  assign sel_op     = grant1 ? req1_op : req0_op;
  assign sel_a      = grant1 ? req1_a  : req0_a;
  assign sel_b      = grant1 ? req1_b  : req0_b;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef CALC_DIVZERO_ERR_EN
  assign sel_divzero = (sel_b == '0);
`else
  assign sel_divzero = 1'b0;
`endif

  // The divider loads straight from the request mux so its DW iterations
  // begin on the cycle after acceptance.
  assign div_start = accept && (sel_op == OP_DIV) && !sel_divzero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = div_start ? ST_DIV : ST_EXEC;
      ST_EXEC:                state_next = ST_RESP;
      ST_DIV:  if (div_done)  state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Subtraction in the full 2*DW width is the sign-extended DW+1 bit
  // difference. A divide only reaches EXEC when it is a trapped divide by
  // zero, which returns zero.
  always_comb begin
    exec_result = '0;
    case (op_q)
      OP_ADD:  exec_result = (2*DW)'(a_q) + (2*DW)'(b_q);
      OP_SUB:  exec_result = (2*DW)'(a_q) - (2*DW)'(b_q);
      OP_MUL:  exec_result = (2*DW)'(a_q) * (2*DW)'(b_q);
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= sel_id;
        ptr  <= sel_id;
      end
      if (state == ST_EXEC) begin
        rsp_data <= exec_result;
        rsp_id   <= id_q;
      end else if ((state == ST_DIV) && div_done) begin
        rsp_data <= {div_rem, div_quo};
        rsp_id   <= id_q;
      end
    end
  end

`ifdef CALC_DIVZERO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_err <= (op_q == OP_DIV);
    end else if ((state == ST_DIV) && div_done) begin
      rsp_err <= 1'b0;
    end
  end
`endif

  calc_div_seq #(
    .DW(DW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (sel_a),
    .divisor   (sel_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule
